// File: rtl/gemm_pe_feeder.sv
// Operand sequencer for one output-stationary MAC PE: streams A/B SRAM words
// for each C element, then drains the PE accumulator to C memory.
module gemm_pe_feeder #(
  parameter int InDataWidth  = 8,
  parameter int NumInputs    = 4,
  parameter int OutDataWidth = 32,
  parameter int DimWidth     = 8,
  parameter int AddrWidth    = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [DimWidth-1:0]              m_i,
  input  logic [DimWidth-1:0]              n_i,
  input  logic [DimWidth-1:0]              kt_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             a_rd_en_o,
  output logic [AddrWidth-1:0]             a_addr_o,
  input  logic [NumInputs*InDataWidth-1:0] a_rdata_i,
  output logic                             b_rd_en_o,
  output logic [AddrWidth-1:0]             b_addr_o,
  input  logic [NumInputs*InDataWidth-1:0] b_rdata_i,
  output logic [NumInputs*InDataWidth-1:0] a_o,
  output logic [NumInputs*InDataWidth-1:0] b_o,
  output logic                             a_valid_o,
  output logic                             b_valid_o,
  output logic                             init_save_o,
  input  logic [OutDataWidth-1:0]          c_i,
  output logic                             c_wvalid_o,
  output logic [AddrWidth-1:0]             c_waddr_o,
  output logic [OutDataWidth-1:0]          c_wdata_o,
  input  logic                             c_wready_i
);

  localparam int ProdWidth = 2 * DimWidth + 1;

  typedef enum logic [2:0] {IDLE, FEED, WAIT, WRITE, DONE} state_e;

  state_e state_q, state_d;
  logic [DimWidth-1:0] m_dim_q, n_dim_q, kt_dim_q;
  logic [DimWidth-1:0] m_q, n_q, k_q;
  logic valid_q, init_q;
  logic k_last, n_last, m_last, any_zero;
  logic [ProdWidth-1:0] a_addr_full, b_addr_full, c_addr_full;

  assign k_last   = (k_q == kt_dim_q - DimWidth'(1));
  assign n_last   = (n_q == n_dim_q - DimWidth'(1));
  assign m_last   = (m_q == m_dim_q - DimWidth'(1));
  assign any_zero = (m_i == '0) || (n_i == '0) || (kt_i == '0);

  assign a_addr_full = ProdWidth'(m_q) * ProdWidth'(kt_dim_q) + ProdWidth'(k_q);
  assign b_addr_full = ProdWidth'(n_q) * ProdWidth'(kt_dim_q) + ProdWidth'(k_q);
  assign c_addr_full = ProdWidth'(m_q) * ProdWidth'(n_dim_q) + ProdWidth'(n_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = any_zero ? DONE : FEED;
      FEED:  if (k_last) state_d = WAIT;
      WAIT:  state_d = WRITE;
      WRITE: if (c_wready_i) state_d = (n_last && m_last) ? DONE : FEED;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // n is the inner loop and m the outer; k rewinds for every output element.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      m_dim_q  <= '0;
      n_dim_q  <= '0;
      kt_dim_q <= '0;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      valid_q  <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == FEED);
      init_q  <= (state_q == FEED) && (k_q == '0);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            m_dim_q  <= m_i;
            n_dim_q  <= n_i;
            kt_dim_q <= kt_i;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
          end
        end
        FEED: k_q <= k_last ? '0 : k_q + DimWidth'(1);
        WRITE: begin
          if (c_wready_i) begin
            k_q <= '0;
            if (n_last) begin
              n_q <= '0;
              m_q <= m_q + DimWidth'(1);
            end else begin
              n_q <= n_q + DimWidth'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and addresses are gated so every output idles at zero outside its phase.
  assign busy_o      = (state_q != IDLE) && (state_q != DONE);
  assign done_o      = (state_q == DONE);
  assign a_rd_en_o   = (state_q == FEED);
  assign b_rd_en_o   = (state_q == FEED);
  assign a_addr_o    = a_rd_en_o ? AddrWidth'(a_addr_full) : '0;
  assign b_addr_o    = b_rd_en_o ? AddrWidth'(b_addr_full) : '0;
  assign a_valid_o   = valid_q;
  assign b_valid_o   = valid_q;
  assign init_save_o = init_q;
  assign a_o         = valid_q ? a_rdata_i : '0;
  assign b_o         = valid_q ? b_rdata_i : '0;
  assign c_wvalid_o  = (state_q == WRITE);
  assign c_waddr_o   = c_wvalid_o ? AddrWidth'(c_addr_full) : '0;
  assign c_wdata_o   = c_wvalid_o ? c_i : '0;

endmodule

// File: tb/tb_gemm_pe_feeder.sv
// Self-checking bench for gemm_pe_feeder: SRAM and PE models, a table of jobs
// compared against a loop-nest golden model, plus a mid-job reset sequence.
module tb_gemm_pe_feeder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  m_i, n_i, kt_i;
  logic        busy_o, done_o;
  logic        a_rd_en_o, b_rd_en_o;
  logic [15:0] a_addr_o, b_addr_o;
  logic [31:0] a_rdata_i, b_rdata_i;
  logic [31:0] a_o, b_o;
  logic        a_valid_o, b_valid_o, init_save_o;
  logic [31:0] c_i;
  logic        c_wvalid_o;
  logic [15:0] c_waddr_o;
  logic [31:0] c_wdata_o;
  logic        c_wready_i;

  gemm_pe_feeder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .m_i(m_i), .n_i(n_i), .kt_i(kt_i),
    .busy_o(busy_o), .done_o(done_o),
    .a_rd_en_o(a_rd_en_o), .a_addr_o(a_addr_o), .a_rdata_i(a_rdata_i),
    .b_rd_en_o(b_rd_en_o), .b_addr_o(b_addr_o), .b_rdata_i(b_rdata_i),
    .a_o(a_o), .b_o(b_o), .a_valid_o(a_valid_o), .b_valid_o(b_valid_o),
    .init_save_o(init_save_o), .c_i(c_i),
    .c_wvalid_o(c_wvalid_o), .c_waddr_o(c_waddr_o), .c_wdata_o(c_wdata_o),
    .c_wready_i(c_wready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {logic [31:0] a; logic [31:0] b; logic init;} beat_t;
  typedef struct packed {logic [15:0] addr; logic [31:0] data;} wr_t;
  typedef struct {
    int m; int n; int kt; int stall; int mode; bit spurious;
    int exp_cycles; bit chk_c0; logic [31:0] exp_c0;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int stall_cfg = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  logic hold_prev = 1'b0;
  logic [15:0] prev_waddr;
  logic [31:0] prev_wdata;

  logic [31:0] a_mem [0:255];
  logic [31:0] b_mem [0:255];
  logic [15:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  beat_t exp_beat[$], obs_beat[$];
  wr_t exp_wr[$], obs_wr[$];
  vec_t vecs[9];

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] s;
    logic signed [7:0] ea, eb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ea = a[8*i +: 8];
      eb = b[8*i +: 8];
      s = s + ea * eb;
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // SRAMs answer one cycle after the read enable; the PE restarts on init_save.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_rdata_i <= '0;
      b_rdata_i <= '0;
    end else begin
      if (a_rd_en_o) a_rdata_i <= a_mem[a_addr_o[7:0]];
      if (b_rd_en_o) b_rdata_i <= b_mem[b_addr_o[7:0]];
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) c_i <= '0;
    else if (a_valid_o) c_i <= (init_save_o ? 32'd0 : c_i) + dot(a_o, b_o);
  end

  // Drives write backpressure and records every observable transaction.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (c_wvalid_o) begin
        if (stall_cnt < stall_cfg) begin
          c_wready_i = 1'b0;
          stall_cnt++;
        end else begin
          c_wready_i = 1'b1;
        end
      end else begin
        c_wready_i = 1'b0;
        stall_cnt = 0;
      end
      if (a_rd_en_o) begin
        obs_a.push_back(a_addr_o);
        obs_b.push_back(b_addr_o);
        checkOutput("b_rd_en_pair", b_rd_en_o, 1);
      end
      if (a_valid_o || b_valid_o) begin
        checkOutput("valid_pair", b_valid_o, a_valid_o);
        obs_beat.push_back({a_o, b_o, init_save_o});
      end
      if (c_wvalid_o)
        checkOutput("quiet_in_write", {a_rd_en_o, b_rd_en_o, a_valid_o, b_valid_o, init_save_o}, 0);
      if (hold_prev)
        checkOutput("write_hold", {c_wvalid_o, c_waddr_o, c_wdata_o}, {1'b1, prev_waddr, prev_wdata});
      if (c_wvalid_o && c_wready_i) obs_wr.push_back({c_waddr_o, c_wdata_o});
      hold_prev  = c_wvalid_o && !c_wready_i;
      prev_waddr = c_waddr_o;
      prev_wdata = c_wdata_o;
      if (done_o) done_cnt++;
    end else begin
      c_wready_i = 1'b0;
      stall_cnt = 0;
      hold_prev = 1'b0;
    end
  end

  task automatic checkIdleOutputs(input string name);
    checkOutput(name, {busy_o, done_o, a_rd_en_o, b_rd_en_o, a_valid_o, b_valid_o, init_save_o,
                       c_wvalid_o, a_addr_o, b_addr_o, c_waddr_o, c_wdata_o, a_o, b_o}, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    bit timed_out;
    logic [31:0] acc;
    stall_cfg = v.stall;
    done_cnt = 0;
    exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
    exp_beat.delete(); obs_beat.delete(); exp_wr.delete(); obs_wr.delete();
    for (int i = 0; i < 256; i++) begin
      case (v.mode)
        1: begin a_mem[i] = 32'h80808080; b_mem[i] = 32'h80808080; end
        2: begin a_mem[i] = 32'h04030201; b_mem[i] = 32'h08070605; end
        default: begin a_mem[i] = $urandom; b_mem[i] = $urandom; end
      endcase
    end
    if (v.m > 0 && v.n > 0 && v.kt > 0) begin
      for (int mm = 0; mm < v.m; mm++)
        for (int nn = 0; nn < v.n; nn++) begin
          acc = 0;
          for (int kk = 0; kk < v.kt; kk++) begin
            exp_a.push_back(16'(mm * v.kt + kk));
            exp_b.push_back(16'(nn * v.kt + kk));
            exp_beat.push_back({a_mem[mm*v.kt+kk], b_mem[nn*v.kt+kk], kk == 0});
            acc = acc + dot(a_mem[mm*v.kt+kk], b_mem[nn*v.kt+kk]);
          end
          exp_wr.push_back({16'(mm * v.n + nn), acc});
        end
    end

    @(negedge clk_i);
    m_i = 8'(v.m); n_i = 8'(v.n); kt_i = 8'(v.kt);
    start_i = 1'b1;
    lat = 0;
    timed_out = 0;
    while (1) begin
      @(negedge clk_i);
      start_i = 1'b0;
      lat++;
      if (lat == 1) checkOutput("busy_after_start", busy_o, exp_wr.size() != 0);
      if (v.spurious && lat == 3) begin
        start_i = 1'b1;
        m_i = 8'd7; n_i = 8'd7; kt_i = 8'd7;
      end
      if (done_o) break;
      if (lat >= 5000) begin timed_out = 1; break; end
    end
    checkOutput("timeout", timed_out, 0);
    checkOutput("latency", lat, v.exp_cycles);
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("done_pulses", done_cnt, 1);
    checkIdleOutputs("idle_after_job");

    checkOutput("read_count", obs_a.size(), exp_a.size());
    checkOutput("beat_count", obs_beat.size(), exp_beat.size());
    checkOutput("write_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      checkOutput("a_addr", obs_a[i], exp_a[i]);
      checkOutput("b_addr", obs_b[i], exp_b[i]);
    end
    for (int i = 0; i < exp_beat.size() && i < obs_beat.size(); i++)
      checkOutput("beat", obs_beat[i], exp_beat[i]);
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      checkOutput("c_write", obs_wr[i], exp_wr[i]);
    if (v.chk_c0) begin
      for (int i = 0; i < obs_wr.size(); i++) checkOutput("c_value", obs_wr[i].data, v.exp_c0);
    end
  endtask

  initial begin
    //          m  n  kt stall mode spur cycles chk c0
    vecs[0] = '{1, 1, 1, 0, 2, 0,  4, 1, 32'd70};
    vecs[1] = '{2, 2, 3, 0, 0, 0, 21, 0, 32'd0};
    vecs[2] = '{1, 2, 2, 5, 0, 0, 19, 0, 32'd0};
    vecs[3] = '{1, 2, 4, 0, 1, 0, 13, 1, 32'd262144};
    vecs[4] = '{0, 3, 3, 0, 0, 0,  1, 0, 32'd0};
    vecs[5] = '{2, 2, 0, 0, 0, 0,  1, 0, 32'd0};
    vecs[6] = '{3, 0, 2, 0, 0, 0,  1, 0, 32'd0};
    vecs[7] = '{3, 2, 1, 0, 0, 1, 19, 0, 32'd0};
    vecs[8] = '{2, 3, 2, 2, 0, 0, 37, 0, 32'd0};

    rst_ni = 1'b0;
    start_i = 1'b0;
    m_i = '0; n_i = '0; kt_i = '0;
    c_wready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checkIdleOutputs("reset_state");
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Abandon a job in FEED, then confirm a fresh job still completes.
    for (int i = 0; i < 256; i++) begin a_mem[i] = $urandom; b_mem[i] = $urandom; end
    @(negedge clk_i);
    m_i = 8'd2; n_i = 8'd2; kt_i = 8'd3;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput("feed_before_reset", a_rd_en_o, 1);
    rst_ni = 1'b0;
    #1;
    checkIdleOutputs("reset_mid_feed");
    @(negedge clk_i);
    checkIdleOutputs("reset_held");
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkIdleOutputs("idle_after_reset");
    applyStimulus(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
